// File: rtl/pwm_deadtime_if.sv
// pwm_deadtime_if: valid/ready port that carries a requested duty value into
// the PWM stage. The producer drives duty/duty_valid; the PWM stage drives
// duty_ready.
interface pwm_deadtime_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH:0] duty;
  logic           duty_valid;
  logic           duty_ready;

  modport master (
    output duty,
    output duty_valid,
    input  duty_ready
  );

  modport slave (
    input  duty,
    input  duty_valid,
    output duty_ready
  );
endinterface

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: center-aligned complementary PWM stage fed by a WIDTH-bit
// up/down triangle carrier. The duty value is double-buffered (pending ->
// active) and only taken over at the carrier valley, so a period is never
// split between two duty values.
//
// Build option: define PWM_DEADTIME_EN to get the dead-time FSM
// (IDLE/LOW_ON/DEAD_H/HIGH_ON/DEAD_L). Without it the outputs are simply the
// registered compare result and the DEAD parameter has no effect.
module pwm_deadtime #(
  parameter int WIDTH = 4,
  parameter int DEAD  = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] x,
  input  logic             en,
  pwm_deadtime_if.slave    duty_if,
  output logic             pwm_h,
  output logic             pwm_l,
  output logic             valley
);

  // Largest meaningful duty: compare is then true for every carrier value.
  localparam logic [WIDTH:0] FULL_SCALE = {1'b1, {WIDTH{1'b0}}};

  // An out-of-range dead time leaves this marker scope in the hierarchy.
  if (DEAD < 1 || DEAD > 15) begin : g_dead_out_of_range
  end

  // Clamp an offered duty to full scale so the compare stays well defined.
  function automatic logic [WIDTH:0] sat_duty(input logic [WIDTH:0] d);
    return (d > FULL_SCALE) ? FULL_SCALE : d;
  endfunction

  logic [WIDTH-1:0] x_prev_q, x_prev_d;
  logic             started_q, started_d;
  logic             full_q, full_d;
  logic [WIDTH:0]   pend_q, pend_d;
  logic [WIDTH:0]   active_q, active_d;
  logic             valley_q, valley_d;
  logic             pwm_h_q, pwm_h_d;
  logic             pwm_l_q, pwm_l_d;

  logic v;
  logic raw;
  logic accept;

  // The carrier dwells two cycles at 0; only the first of them is a valley.
  // Before the first valley (or after en drops) any 0 counts.
  assign v      = (x == '0) && ((x_prev_q != '0) || !started_q);
  assign raw    = ({1'b0, x} < active_q);
  assign accept = duty_if.duty_valid && !full_q;

  assign duty_if.duty_ready = !full_q;
  assign pwm_h              = pwm_h_q;
  assign pwm_l              = pwm_l_q;
  assign valley             = valley_q;

  // Valley tracking and duty double-buffer next state.
  always_comb begin
    x_prev_d  = x;
    valley_d  = v;
    started_d = en ? (started_q | v) : 1'b0;
    full_d    = full_q;
    pend_d    = pend_q;
    active_d  = active_q;
    // The valley looks at the registered full flag, so a value accepted on
    // this very cycle waits for the following valley.
    if (v && full_q) begin
      active_d = pend_q;
      full_d   = 1'b0;
    end
    if (accept) begin
      pend_d = sat_duty(duty_if.duty);
      full_d = 1'b1;
    end
  end

  // Valley and duty-buffer registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_prev_q  <= '0;
      started_q <= 1'b0;
      full_q    <= 1'b0;
      pend_q    <= '0;
      active_q  <= '0;
      valley_q  <= 1'b0;
    end else begin
      x_prev_q  <= x_prev_d;
      started_q <= started_d;
      full_q    <= full_d;
      pend_q    <= pend_d;
      active_q  <= active_d;
      valley_q  <= valley_d;
    end
  end

`ifdef PWM_DEADTIME_EN

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOW_ON,
    S_DEAD_H,
    S_HIGH_ON,
    S_DEAD_L
  } state_t;

  localparam logic [3:0] DEAD_LOAD = 4'(DEAD);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  // Dead-time sequencing: a side is switched on only after the compare has
  // held for the full dead time; a compare that reverts mid dead time hands
  // control back to the side that was just on, which cannot overlap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (v) begin
            state_d = raw ? S_DEAD_H : S_DEAD_L;
            cnt_d   = DEAD_LOAD;
          end
        end
        S_LOW_ON: begin
          if (raw) begin
            state_d = S_DEAD_H;
            cnt_d   = DEAD_LOAD;
          end
        end
        S_HIGH_ON: begin
          if (!raw) begin
            state_d = S_DEAD_L;
            cnt_d   = DEAD_LOAD;
          end
        end
        S_DEAD_H: begin
          if (!raw) begin
            state_d = S_LOW_ON;
          end else if (cnt_q <= 4'd1) begin
            state_d = S_HIGH_ON;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        S_DEAD_L: begin
          if (raw) begin
            state_d = S_HIGH_ON;
          end else if (cnt_q <= 4'd1) begin
            state_d = S_LOW_ON;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    pwm_h_d = (state_d == S_HIGH_ON);
    pwm_l_d = (state_d == S_LOW_ON);
  end

  // FSM state, dead counter and registered drive outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pwm_h_q <= 1'b0;
      pwm_l_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pwm_h_q <= pwm_h_d;
      pwm_l_q <= pwm_l_d;
    end
  end

`else

  logic run;

  // Without dead time the outputs are the registered compare, gated to zero
  // until the first valley after enable.
  always_comb begin
    run     = en && (started_q || v);
    pwm_h_d = run && raw;
    pwm_l_d = run && !raw;
  end

  // Registered drive outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pwm_h_q <= 1'b0;
      pwm_l_q <= 1'b0;
    end else begin
      pwm_h_q <= pwm_h_d;
      pwm_l_q <= pwm_l_d;
    end
  end

`endif

endmodule

// File: tb/tb_pwm_deadtime.sv
// tb_pwm_deadtime: bench for pwm_deadtime. A triangle carrier is generated
// here; a cycle model of the duty buffer and output rules predicts every
// output. Works for either build (PWM_DEADTIME_EN defined or not).
`timescale 1ns/1ps
module tb_pwm_deadtime;

  localparam int WIDTH  = 4;
  localparam int DEAD   = 3;
  localparam int PERIOD = 2 << WIDTH;
  localparam int FULL   = 1 << WIDTH;
`ifdef PWM_DEADTIME_EN
  localparam int LOSS = DEAD;
`else
  localparam int LOSS = 0;
`endif
  // Consecutive cycles the compare must favour a side before it turns on.
  localparam int TH = LOSS + 1;

  logic             clock = 1'b0;
  logic             reset;
  logic             en;
  logic [WIDTH-1:0] x;
  logic             pwm_h, pwm_l, valley;

  pwm_deadtime_if #(.WIDTH(WIDTH)) dif ();

  pwm_deadtime #(.WIDTH(WIDTH), .DEAD(DEAD)) dut (
    .clock   (clock),
    .reset   (reset),
    .x       (x),
    .en      (en),
    .duty_if (dif),
    .pwm_h   (pwm_h),
    .pwm_l   (pwm_l),
    .valley  (valley)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int pos;

  // reference model state
  logic [WIDTH-1:0] m_xd;
  logic             m_started;
  logic             m_full;
  logic [WIDTH:0]   m_pend;
  logic [WIDTH:0]   m_active;
  int               m_owner;   // 0 none, 1 high side, 2 low side
  int               m_agree;

  typedef struct {
    logic [WIDTH:0] duty;
    int             exp_h;
    int             exp_l;
  } vec_t;
  vec_t tbl[8];

  function automatic logic [WIDTH-1:0] carrier_at(input int p);
    int v;
    if (p < 2)        v = 0;
    else if (p <= 16) v = p - 1;
    else if (p == 17) v = 15;
    else              v = PERIOD - p;
    return v[WIDTH-1:0];
  endfunction

  function automatic int sat(input int d);
    return (d > FULL) ? FULL : d;
  endfunction

  function automatic int exp_high(input int d);
    int s = sat(d);
    if (s == 0) return 0;
    if (s == FULL) return PERIOD;
    return 2 * s - LOSS;
  endfunction

  function automatic int exp_low(input int d);
    int s = sat(d);
    if (s == 0) return PERIOD;
    if (s == FULL) return 0;
    return PERIOD - 2 * s - LOSS;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mreset();
    m_xd = '0; m_started = 1'b0; m_full = 1'b0;
    m_pend = '0; m_active = '0; m_owner = 0; m_agree = 0;
  endtask

  function automatic logic pred_v();
    return (x == '0) && (m_xd != '0 || !m_started);
  endfunction

  // One clock: predict, advance, compare outputs, move the carrier.
  task automatic step();
    logic pv, praw, prun;
    int   fav, on;
    chk("duty_ready", int'(dif.duty_ready), int'(!m_full));
    pv   = pred_v();
    praw = ({1'b0, x} < m_active);
    prun = en && (m_started || pv);
    on   = 0;
    if (prun) begin
      if (!m_started) begin
        m_owner = praw ? 2 : 1;
        m_agree = 0;
      end
      fav = praw ? 1 : 2;
      if (fav == m_owner) begin
        m_agree = 0;
        on = fav;
      end else begin
        m_agree++;
        if (m_agree >= TH) begin
          m_owner = fav;
          m_agree = 0;
          on = fav;
        end
      end
    end
    if (pv && m_full) begin
      m_active = m_pend;
      m_full = 1'b0;
    end
    if (dif.duty_valid && !(m_full || (pv && 1'b0))) begin
      if (dif.duty_ready) begin
        m_pend = (WIDTH+1)'(sat(int'(dif.duty)));
        m_full = 1'b1;
      end
    end
    m_started = en ? (m_started || pv) : 1'b0;
    m_xd = x;
    @(posedge clock);
    #1;
    chk("pwm_h", int'(pwm_h), int'(on == 1));
    chk("pwm_l", int'(pwm_l), int'(on == 2));
    chk("valley", int'(valley), int'(pv));
    chk("no_overlap", int'(pwm_h & pwm_l), 0);
    pos = (pos + 1) % PERIOD;
    x = carrier_at(pos);
  endtask

  task automatic offer(input int d);
    bit done = 0;
    dif.duty = (WIDTH+1)'(d);
    dif.duty_valid = 1'b1;
    for (int c = 0; c < 100 && !done; c++) begin
      if (dif.duty_ready) done = 1;
      step();
    end
    dif.duty_valid = 1'b0;
    if (!done) chk("offer_timeout", 0, 1);
  endtask

  // Count drive cycles over one period and check every dead gap.
  task automatic measure(input string tag, output int hc, output int lc);
    int gap = -1;
    int last = 0;
    int cur;
    hc = 0; lc = 0;
    for (int c = 0; c < PERIOD; c++) begin
      step();
      hc += int'(pwm_h);
      lc += int'(pwm_l);
      cur = pwm_h ? 1 : (pwm_l ? 2 : 0);
      if (cur == 0) begin
        if (gap >= 0) gap++;
      end else begin
        if (gap >= 0 && cur != last) chk({tag, "_dead_gap"}, gap, LOSS);
        last = cur;
        gap = 0;
      end
    end
  endtask

  initial begin
    int duties[8] = '{8, 4, 0, 16, 31, 2, 14, 12};
    int hc, lc, fz, fv, stalls;
    bit found;

    for (int i = 0; i < 8; i++) begin
      tbl[i].duty  = (WIDTH+1)'(duties[i]);
      tbl[i].exp_h = exp_high(duties[i]);
      tbl[i].exp_l = exp_low(duties[i]);
    end

    reset = 1'b1; en = 1'b0;
    dif.duty = '0; dif.duty_valid = 1'b0;
    pos = 5; x = carrier_at(pos);
    mreset();
    #2;
    chk("rst_pwm_h", int'(pwm_h), 0);
    chk("rst_pwm_l", int'(pwm_l), 0);
    chk("rst_valley", int'(valley), 0);
    chk("rst_ready", int'(dif.duty_ready), 1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    en = 1'b1;

    // first valley: one cycle after x first reads 0
    fz = -1; fv = -1;
    for (int c = 0; c < 2 * PERIOD && fv < 0; c++) begin
      if (fz < 0 && x == '0) fz = c;
      step();
      if (valley && fv < 0) fv = c + 1;
    end
    if (fv < 0) chk("first_valley_timeout", 0, 1);
    else        chk("first_valley_latency", fv - fz, 1);

    // table: steady-state drive per period for each duty
    for (int i = 0; i < 8; i++) begin
      offer(int'(tbl[i].duty));
      repeat (70) step();
      measure($sformatf("tbl%0d", i), hc, lc);
      chk($sformatf("tbl%0d_high", i), hc, tbl[i].exp_h);
      chk($sformatf("tbl%0d_low", i), lc, tbl[i].exp_l);
    end

    // back-to-back offers: 9 stalls until the valley that loads 5
    chk("hs_ready_for_5", int'(dif.duty_ready), 1);
    dif.duty = 5'd5; dif.duty_valid = 1'b1;
    step();
    dif.duty = 5'd9;
    stalls = 0;
    found = 0;
    for (int c = 0; c < 80 && !found; c++) begin
      if (dif.duty_ready) found = 1;
      else begin
        stalls++;
        step();
      end
    end
    if (!found) chk("hs_stall_timeout", 0, 1);
    chk("hs_stalled", int'(stalls > 0), 1);
    chk("hs_ready_at_valley", int'(valley), 1);
    step();
    dif.duty_valid = 1'b0;
    repeat (70) step();
    measure("hs9", hc, lc);
    chk("hs9_high", hc, exp_high(9));

    // accept exactly on a valley cycle: old duty kept for this period
    found = 0;
    for (int c = 0; c < 2 * PERIOD && !found; c++) begin
      if (pred_v()) found = 1;
      else step();
    end
    if (!found) chk("vacc_timeout", 0, 1);
    dif.duty = 5'd12; dif.duty_valid = 1'b1;
    step();
    dif.duty_valid = 1'b0;
    measure("vacc_old", hc, lc);
    chk("vacc_old_high", hc, exp_high(9));
    measure("vacc_new", hc, lc);
    chk("vacc_new_high", hc, exp_high(12));

    // drop enable while the high side is on
    found = 0;
    for (int c = 0; c < 2 * PERIOD && !found; c++) begin
      if (pwm_h) found = 1;
      else step();
    end
    if (!found) chk("en_wait_high_timeout", 0, 1);
    en = 1'b0;
    step();
    chk("en_off_h", int'(pwm_h), 0);
    chk("en_off_l", int'(pwm_l), 0);
    repeat (5) step();
    en = 1'b1;
    found = 0;
    for (int c = 0; c < 2 * PERIOD && !found; c++) begin
      step();
      if (valley) found = 1;
      else chk("en_hold_zero", int'(pwm_h | pwm_l), 0);
    end
    if (!found) chk("en_valley_timeout", 0, 1);

    // asynchronous reset between edges, with a pending duty held
    repeat (10) step();
    dif.duty = 5'd7; dif.duty_valid = 1'b1;
    found = 0;
    for (int c = 0; c < 2 * PERIOD && !found; c++) begin
      if (dif.duty_ready) found = 1;
      step();
    end
    dif.duty_valid = 1'b0;
    found = 0;
    for (int c = 0; c < 4 && !found; c++) begin
      if (!pred_v()) found = 1;
      else step();
    end
    chk("ar_pending_full", int'(dif.duty_ready), 0);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_pwm_h", int'(pwm_h), 0);
    chk("ar_pwm_l", int'(pwm_l), 0);
    chk("ar_valley", int'(valley), 0);
    chk("ar_ready", int'(dif.duty_ready), 1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    mreset();

    // randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      dif.duty_valid = ($urandom_range(0, 3) == 0);
      dif.duty = (WIDTH+1)'($urandom_range(0, 31));
      if ($urandom_range(0, 99) == 0) en = ~en;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pwm_deadtime.md
# pwm_deadtime

Center-aligned complementary PWM stage driven by the 4-bit up/down triangle counter that precedes it. It compares the carrier against a duty value double-buffered through a valid/ready port and applied only at the carrier valley. It drives a high-side/low-side output pair with programmable dead time. It is the direct consumer of the triangle counter's output `x`.

## Interface

Parameters:
- `WIDTH`, default 4: carrier width; must match the upstream counter.
- `DEAD`, default 2: dead-time length in clock cycles; legal range 1..15.

Ports:
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state immediately.
- `x`  in  WIDTH: triangle carrier from the upstream counter.
- `en`  in  1: output enable.
- `duty`  in  WIDTH+1: requested duty; range 0..2^WIDTH.
- `duty_valid`  in  1: `duty` is offered.
- `duty_ready`  out  1: pending buffer is empty; an offer is accepted this cycle.
- `pwm_h`  out  1: high-side drive.
- `pwm_l`  out  1: low-side drive.
- `valley`  out  1: one-cycle pulse marking a duty load point.

## Operation

- **Reset values:** `pwm_h`=0, `pwm_l`=0, `valley`=0, `duty_ready`=1. Pending buffer is empty, active duty is 0, `started`=0, FSM is in IDLE, `x_d`=0.
- **Valley event `v`:**
  - `v` = (`x`==0) && (`x_d`!=0 || !`started`), where `x_d` is `x` registered.
  - `v` fires on the first cycle of each dwell at 0. The upstream counter holds 0 for two cycles.
- **Duty buffering:**
  - Accept when `duty_valid` && `duty_ready`: pending ← `duty`, pending becomes full.
  - On `v` with pending full: active ← pending, pending becomes empty.
  - On `v` with pending empty: active duty is kept unchanged.
  - `v` also sets `started`.
  - The valley check uses the registered full flag. A value accepted on the same cycle as `v` waits for the next valley.
  - Values of `duty` above 2^WIDTH are saturated to 2^WIDTH on accept.
- **Compare:** `raw` = (`x` < active), evaluated at full WIDTH+1 width.
  - Active 0 gives `raw` always 0.
  - Active 2^WIDTH gives `raw` always 1.
- **FSM states:** IDLE, LOW_ON, DEAD_H, HIGH_ON, DEAD_L.
  - IDLE: both outputs 0. On `v` with `en`=1, go to DEAD_H if `raw`=1, else DEAD_L, and load the dead counter with DEAD.
  - LOW_ON: `pwm_l`=1. On `raw`=1, go to DEAD_H and load the counter.
  - HIGH_ON: `pwm_h`=1. On `raw`=0, go to DEAD_L and load the counter.
  - DEAD_H / DEAD_L: both outputs 0; the counter decrements each cycle.
    - At counter 1, go to HIGH_ON (from DEAD_H) or LOW_ON (from DEAD_L).
    - If `raw` reverts during DEAD_H, go back to LOW_ON next cycle. If it reverts during DEAD_L, go back to HIGH_ON next cycle. Only the switch that was just on is re-enabled, so there is no overlap.
- **`en`=0:** from any state, go to IDLE next cycle and clear `started`. Outputs restart at the next valley after `en` returns to 1. The duty buffers are unaffected.
- **Invariant:** `pwm_h` && `pwm_l` is never 1.
- **Reset mid-operation:** all outputs drop asynchronously. A pending duty is discarded.

## Timing

- `valley` is registered: it asserts the cycle after `x` first reads 0.
- **Latency:** a change of `x` reaches the FSM's `raw` decision combinationally, and the outputs are registered. An edge in `raw` therefore removes the on-side output 1 cycle later and asserts the opposite output DEAD+1 cycles after the `raw` edge.
- `duty_ready` drops the cycle after an accept and rises the cycle after the consuming valley.
- **Carrier period:** 2·2^WIDTH cycles (32 at WIDTH=4). The counter dwells two cycles at each extreme.
- **High time per period:** 2·active cycles before dead-time loss. Active 2^WIDTH gives 100%.

## Configuration

- `PWM_DEADTIME_EN` defined: dead-time FSM as described.
- `PWM_DEADTIME_EN` undefined:
  - DEAD states are removed and the `DEAD` parameter is ignored.
  - After `started` with `en`=1: `pwm_h` = registered `raw`, `pwm_l` = registered !`raw`. Both are 0 in IDLE.
  - Handshake and valley logic are identical in both builds.

## Test plan

- **Reset and first load:** reset, then offer `duty`=8 while the carrier runs.
  - First `valley` 1 cycle after `x`=0.
  - `pwm_h` high 16 cycles minus dead time, per 32-cycle period.
  - `pwm_h`/`pwm_l` never both 1.
- **Dead time:** DEAD=3, `duty`=4.
  - Every `pwm_h` fall is followed by exactly 3 cycles with both outputs low, then `pwm_l` rises.
  - The mirror image holds on the rise.
- **Extremes:**
  - `duty`=0: `pwm_l` stays 1 and `pwm_h` stays 0 after the first valley.
  - `duty`=16: `pwm_h` stays 1 and `pwm_l` stays 0.
  - `duty`=31 saturates to 16.
- **Handshake:**
  - Offer 5, then 9 back-to-back: 9 is stalled (`duty_ready`=0) until the valley that loads 5.
  - 9 is applied one period later.
- **Accept on a valley cycle:** with pending empty, offer 12 exactly on the `v` cycle.
  - The old duty is kept this period; 12 is applied at the next valley.
- **Enable and async reset:**
  - Drop `en` mid-HIGH_ON: both outputs 0 next cycle, and they stay 0 until the first valley after `en` is re-asserted.
  - Assert `reset` between clock edges: outputs clear without waiting for a clock edge.
